ram_arb: RTL and testbench
==========================

RAM_ARB -- requirements
Module: ram_arb

Interface
REQ-001 Parameter RR, default 1, meaning 1 = round-robin between masters, 0 = fixed priority with master 0 winning.
REQ-002 Parameter TIMEOUT, default 16, meaning the number of WAIT cycles without s_ready before the transaction is aborted with error; range 2..255.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous reset, active-high.
REQ-006 Ports m0_valid / m1_valid, input, 1 bit each: master request; held high until that master's m*_ready.
REQ-007 Ports m0_write / m1_write, input, 1 bit each: 1 = write, 0 = read.
REQ-008 Ports m0_addr / m1_addr, input, 32 bits each: byte address.
REQ-009 Ports m0_size / m1_size, input, 2 bits each: 0 = byte, 1 = half, 2 = word.
REQ-010 Ports m0_wdata / m1_wdata, input, 32 bits each: write data, LSB-aligned.
REQ-011 Ports m0_ready / m1_ready, output, 1 bit each: one-cycle completion pulse.
REQ-012 Ports m0_err / m1_err, output, 1 bit each: asserted together with m*_ready on timeout.
REQ-013 Ports m0_rdata / m1_rdata, output, 32 bits each: read data, valid only while m*_ready is high.
REQ-014 Ports s_valid, s_write, s_addr (32 bits), s_size (2 bits), s_wdata (32 bits), output: the shared RAM-side request.
REQ-015 Port s_ready, input, 1 bit: RAM completion, arriving one cycle after s_valid.
REQ-016 Port s_rdata, input, 32 bits: RAM read data, combinationally dependent on s_addr.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT.
REQ-018 IDLE, with any m*_valid high: select a winner, latch its write/addr/size/wdata into the s_* registers, record the grant, go to ISSUE.
REQ-019 IDLE, with no valid high: stay in IDLE; s_* fields hold their previous values.
REQ-020 ISSUE: s_valid=1 for exactly one cycle; unconditional transition to WAIT.
REQ-021 WAIT: s_valid=0.
REQ-022 WAIT: s_addr, s_size, s_write and s_wdata stay stable, because RAM read data depends on the address in the ready cycle.
REQ-023 WAIT with s_ready=1: the granted m*_ready=1 and m*_rdata=s_rdata in the same cycle (combinational), then go to IDLE.
REQ-024 A 8-bit timeout counter clears on entry to WAIT and increments each WAIT cycle.
REQ-025 When the counter reaches TIMEOUT-1 without s_ready: the granted m*_ready=1 and m*_err=1, then go to IDLE.
REQ-026 Minimum latency: m*_valid sampled in IDLE at cycle N gives m*_ready at cycle N+2; the next grant is possible at N+3.
REQ-027 Arbitration with RR=1: a 1-bit last-grant pointer; on a simultaneous request the master not granted last wins; the pointer updates on every grant.
REQ-028 Arbitration with RR=0: master 0 always wins a simultaneous request.
REQ-029 A single requester is granted immediately, regardless of the pointer.
REQ-030 The non-granted master's m*_ready, m*_err and m*_rdata stay 0 at all times.
REQ-031 A master dropping valid mid-transaction does not abort it; the transaction completes and the ready pulse is still issued.
REQ-032 s_ready seen outside WAIT is ignored.
REQ-033 Exactly one RAM write per write transaction: s_valid is high for a single cycle.

Reset
REQ-034 While rst=1 at a clock edge: state=IDLE, s_valid=0, and s_write, s_addr, s_size, s_wdata=0.
REQ-035 While rst=1 at a clock edge: the pointer selects master 0 as first winner, and the timeout counter=0.
REQ-036 All m*_ready and m*_err are 0 during and immediately after reset.
REQ-037 Reset asserted in ISSUE or WAIT abandons the transaction with no ready pulse; the master must re-request.

Structure
REQ-038 Package ram_pkg holds the FSM state enum (IDLE/ISSUE/WAIT) and the size constants SZ_B=0, SZ_H=1, SZ_W=2.
REQ-039 Sub-module arb2: two-input grant logic with the RR parameter and the last-grant pointer register; everything else is inline in ram_arb.

Verification
REQ-040 m0 read of addr 0x4 (word 0x11223344) at cycle 1 -> s_valid in cycle 2 only, m0_ready and m0_rdata=0x11223344 in cycle 3, m1 outputs 0.
REQ-041 RR=1, m0 and m1 both valid from reset -> grants m0, m1, m0, m1 in order, ready pulses 3 cycles apart.
REQ-042 RR=0, both valid continuously -> m0 served every 3 cycles, m1 never served until m0 drops valid.
REQ-043 m1 byte write 0xAB to addr 0x6, size 0 -> exactly one s_valid cycle with s_addr=0x6, s_size=0, s_wdata=0xAB; readback word shows 0xAB in bits 23:16.
REQ-044 s_ready tied 0, TIMEOUT=4 -> m0_ready with m0_err=1 four cycles after entering WAIT, FSM back in IDLE.
REQ-045 rst pulsed during WAIT -> no m*_ready, s_valid=0, next request is granted normally with m0 as first winner.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and constants for the two-master RAM arbiter.
package ram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

endpackage

// File: rtl/ram_arb_arb2.sv
// Two-input grant selection with a last-grant pointer for round-robin mode.
module arb2 #(
    parameter int RR = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic       gnt
);

    logic last;

    // Pointer resets to 1 so that master 0 wins the first contested grant.
    always_comb begin
        gnt = 1'b0;
        if (req == 2'b10)
            gnt = 1'b1;
        else if (req == 2'b11 && RR != 0)
            gnt = ~last;
    end

    always_ff @(posedge clk) begin
        if (rst)
            last <= 1'b1;
        else if (take)
            last <= gnt;
    end

endmodule

// File: rtl/ram_arb.sv
// Arbitrates two masters onto a single RAM port with completion timeout.
module ram_arb
    import ram_pkg::*;
#(
    parameter int RR      = 1,
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_valid,
    input  logic        m0_write,
    input  logic [31:0] m0_addr,
    input  logic [1:0]  m0_size,
    input  logic [31:0] m0_wdata,
    output logic        m0_ready,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic        m1_write,
    input  logic [31:0] m1_addr,
    input  logic [1:0]  m1_size,
    input  logic [31:0] m1_wdata,
    output logic        m1_ready,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic        s_write,
    output logic [31:0] s_addr,
    output logic [1:0]  s_size,
    output logic [31:0] s_wdata,
    input  logic        s_ready,
    input  logic [31:0] s_rdata
);

    state_t     state;
    logic       gnt_q;
    logic       win;
    logic       take;
    logic [7:0] cnt;
    logic       tmo;
    logic       done;

    assign take = (state == IDLE) && (m0_valid || m1_valid);

    arb2 #(.RR(RR)) u_arb (
        .clk  (clk),
        .rst  (rst),
        .req  ({m1_valid, m0_valid}),
        .take (take),
        .gnt  (win)
    );

    assign tmo     = (state == WAIT) && !s_ready && (cnt == 8'(TIMEOUT - 1));
    // Completion is suppressed while rst is high so no pulse escapes a reset.
    assign done    = !rst && (state == WAIT) && (s_ready || tmo);
    assign s_valid = (state == ISSUE);

    always_comb begin
        m0_ready = done && !gnt_q;
        m1_ready = done && gnt_q;
        m0_err   = m0_ready && !s_ready;
        m1_err   = m1_ready && !s_ready;
        m0_rdata = (m0_ready && s_ready) ? s_rdata : '0;
        m1_rdata = (m1_ready && s_ready) ? s_rdata : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gnt_q   <= 1'b0;
            cnt     <= '0;
            s_write <= 1'b0;
            s_addr  <= '0;
            s_size  <= '0;
            s_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        gnt_q <= win;
                        if (win) begin
                            s_write <= m1_write;
                            s_addr  <= m1_addr;
                            s_size  <= m1_size;
                            s_wdata <= m1_wdata;
                        end else begin
                            s_write <= m0_write;
                            s_addr  <= m0_addr;
                            s_size  <= m0_size;
                            s_wdata <= m0_wdata;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (s_ready || tmo)
                        state <= IDLE;
                    else
                        cnt <= cnt + 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arb.sv
// Directed bench for ram_arb with a transaction-level timing model and a byte RAM.
module tb_ram_arb;
    import ram_pkg::*;

    localparam int TO0 = 4;
    localparam int TO1 = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mclr = 1'b1;
    always #5 clk = ~clk;

    logic        mv[2][2], mw[2][2];
    logic [31:0] ma[2][2], md[2][2];
    logic [1:0]  ms[2][2];
    logic        rdy[2][2], er[2][2];
    logic [31:0] rd[2][2];
    logic        sv[2], sw[2], srdy[2], ram_en[2];
    logic [31:0] sa[2], sd[2], srd[2];
    logic [1:0]  ss[2];
    logic [7:0]  mem[2][64];

    int ncmp = 0;
    int nbad = 0;
    int cyc = 0;

    ram_arb #(.RR(1), .TIMEOUT(TO0)) u0 (
        .clk(clk), .rst(rst),
        .m0_valid(mv[0][0]), .m0_write(mw[0][0]), .m0_addr(ma[0][0]), .m0_size(ms[0][0]),
        .m0_wdata(md[0][0]), .m0_ready(rdy[0][0]), .m0_err(er[0][0]), .m0_rdata(rd[0][0]),
        .m1_valid(mv[0][1]), .m1_write(mw[0][1]), .m1_addr(ma[0][1]), .m1_size(ms[0][1]),
        .m1_wdata(md[0][1]), .m1_ready(rdy[0][1]), .m1_err(er[0][1]), .m1_rdata(rd[0][1]),
        .s_valid(sv[0]), .s_write(sw[0]), .s_addr(sa[0]), .s_size(ss[0]), .s_wdata(sd[0]),
        .s_ready(srdy[0]), .s_rdata(srd[0])
    );

    ram_arb #(.RR(0), .TIMEOUT(TO1)) u1 (
        .clk(clk), .rst(rst),
        .m0_valid(mv[1][0]), .m0_write(mw[1][0]), .m0_addr(ma[1][0]), .m0_size(ms[1][0]),
        .m0_wdata(md[1][0]), .m0_ready(rdy[1][0]), .m0_err(er[1][0]), .m0_rdata(rd[1][0]),
        .m1_valid(mv[1][1]), .m1_write(mw[1][1]), .m1_addr(ma[1][1]), .m1_size(ms[1][1]),
        .m1_wdata(md[1][1]), .m1_ready(rdy[1][1]), .m1_err(er[1][1]), .m1_rdata(rd[1][1]),
        .s_valid(sv[1]), .s_write(sw[1]), .s_addr(sa[1]), .s_size(ss[1]), .s_wdata(sd[1]),
        .s_ready(srdy[1]), .s_rdata(srd[1])
    );

    // Byte RAM: answers one cycle after s_valid, read data follows s_addr.
    assign srd[0] = {mem[0][{sa[0][5:2], 2'd3}], mem[0][{sa[0][5:2], 2'd2}],
                     mem[0][{sa[0][5:2], 2'd1}], mem[0][{sa[0][5:2], 2'd0}]};
    assign srd[1] = {mem[1][{sa[1][5:2], 2'd3}], mem[1][{sa[1][5:2], 2'd2}],
                     mem[1][{sa[1][5:2], 2'd1}], mem[1][{sa[1][5:2], 2'd0}]};

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mclr) begin
                srdy[k] <= 1'b0;
                for (int i = 0; i < 64; i++) mem[k][i] <= 8'h00;
            end else begin
                srdy[k] <= sv[k] && ram_en[k];
                if (sv[k] && sw[k]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (b < (ss[k] == SZ_B ? 1 : ss[k] == SZ_H ? 2 : 4))
                            mem[k][6'(sa[k][5:0] + 6'(b))] <= sd[k][8*b +: 8];
                    end
                end
            end
        end
    end

    function automatic logic [31:0] wordm(input int k, input logic [31:0] a);
        return {mem[k][{a[5:2], 2'd3}], mem[k][{a[5:2], 2'd2}],
                mem[k][{a[5:2], 2'd1}], mem[k][{a[5:2], 2'd0}]};
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", n, cyc, act, exp);
        end
    endtask

    // Model: each transaction is a grant cycle, one issue cycle, then completion
    // either one cycle later (RAM answers) or after TIMEOUT wait cycles.
    bit          busy[2], last[2], mst[2], mwr[2], resp[2];
    int          t_iss[2], t_done[2];
    logic [31:0] maddr[2], mwd[2];
    logic [1:0]  msz[2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            busy[k] = 0; last[k] = 1; t_iss[k] = 0; t_done[k] = 0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            for (int k = 0; k < 2; k++) begin
                if (busy[k] && cyc == t_iss[k]) begin
                    resp[k]   = ram_en[k];
                    t_done[k] = resp[k] ? t_iss[k] + 1 : t_iss[k] + (k == 0 ? TO0 : TO1);
                end
                chk($sformatf("s_valid[%0d]", k), 32'(sv[k]), 32'(busy[k] && cyc == t_iss[k]));
                if (busy[k] && cyc >= t_iss[k]) begin
                    chk($sformatf("s_addr[%0d]", k), sa[k], maddr[k]);
                    chk($sformatf("s_size[%0d]", k), 32'(ss[k]), 32'(msz[k]));
                    chk($sformatf("s_write[%0d]", k), 32'(sw[k]), 32'(mwr[k]));
                    chk($sformatf("s_wdata[%0d]", k), sd[k], mwd[k]);
                end
                for (int m = 0; m < 2; m++) begin
                    bit er_exp, rd_exp;
                    rd_exp = !rst && busy[k] && cyc > t_iss[k] && cyc == t_done[k] && mst[k] == m[0];
                    er_exp = rd_exp && !resp[k];
                    chk($sformatf("ready[%0d][%0d]", k, m), 32'(rdy[k][m]), 32'(rd_exp));
                    chk($sformatf("err[%0d][%0d]", k, m), 32'(er[k][m]), 32'(er_exp));
                    chk($sformatf("rdata[%0d][%0d]", k, m), rd[k][m],
                        (rd_exp && resp[k]) ? wordm(k, maddr[k]) : 32'h0);
                end
                if (rst) begin
                    busy[k] = 0;
                    last[k] = 1;
                end else if (busy[k]) begin
                    if (cyc > t_iss[k] && cyc == t_done[k]) busy[k] = 0;
                end else if (mv[k][0] || mv[k][1]) begin
                    bit w;
                    if (mv[k][0] && mv[k][1]) w = (k == 0) ? !last[k] : 1'b0;
                    else                      w = mv[k][1];
                    busy[k]  = 1;
                    mst[k]   = w;
                    last[k]  = w;
                    t_iss[k] = cyc + 1;
                    t_done[k] = cyc + 1;
                    mwr[k]   = mw[k][w];
                    maddr[k] = ma[k][w];
                    msz[k]   = ms[k][w];
                    mwd[k]   = md[k][w];
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int k, input int m, input bit w, input logic [31:0] a,
                       input logic [1:0] s, input logic [31:0] d);
        mv[k][m] = 1'b1; mw[k][m] = w; ma[k][m] = a; ms[k][m] = s; md[k][m] = d;
    endtask

    task automatic wait_ready(input int k, input int m, input int lim, output int n);
        bit got = 0;
        n = 0;
        while (!got && n < lim) begin
            @(negedge clk);
            n++;
            got = rdy[k][m];
        end
        chk($sformatf("wait_ready[%0d][%0d]", k, m), 32'(got), 32'd1);
    endtask

    task automatic xact(input int k, input int m, input bit w, input logic [31:0] a,
                        input logic [1:0] s, input logic [31:0] d);
        int n;
        req(k, m, w, a, s, d);
        wait_ready(k, m, 40, n);
        step();
        mv[k][m] = 1'b0;
    endtask

    initial begin
        int n;
        int q_m[$];
        int q_c[$];
        int c0m, c1m;
        for (int k = 0; k < 2; k++) begin
            ram_en[k] = 1'b1;
            for (int m = 0; m < 2; m++) begin
                mv[k][m] = 0; mw[k][m] = 0; ma[k][m] = '0; ms[k][m] = '0; md[k][m] = '0;
            end
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready0", 32'(rdy[0][0]), 32'd0);
        chk("rst_svalid0", 32'(sv[0]), 32'd0);
        chk("rst_saddr0", sa[0], 32'h0);
        step();
        rst = 1'b0; mclr = 1'b0;
        @(negedge clk);
        chk("post_rst_ready1", 32'(rdy[1][1]), 32'd0);
        step();

        // Word write, then the single read with pinned cycle-by-cycle values.
        xact(0, 0, 1'b1, 32'h4, SZ_W, 32'h11223344);
        req(0, 0, 1'b0, 32'h4, SZ_W, 32'h0);
        @(negedge clk); chk("r_sv_grant", 32'(sv[0]), 32'd0);
        @(negedge clk); chk("r_sv_issue", 32'(sv[0]), 32'd1);
        chk("r_rdy_issue", 32'(rdy[0][0]), 32'd0);
        @(negedge clk); chk("r_sv_wait", 32'(sv[0]), 32'd0);
        chk("r_rdy", 32'(rdy[0][0]), 32'd1);
        chk("r_rdata", rd[0][0], 32'h11223344);
        chk("r_m1_rdy", 32'(rdy[0][1]), 32'd0);
        chk("r_m1_rdata", rd[0][1], 32'h0);
        step(); mv[0][0] = 0;

        // Byte write from master 1, then word readback.
        req(0, 1, 1'b1, 32'h6, SZ_B, 32'h000000AB);
        @(negedge clk);
        @(negedge clk);
        chk("bw_sv", 32'(sv[0]), 32'd1);
        chk("bw_addr", sa[0], 32'h6);
        chk("bw_size", 32'(ss[0]), 32'd0);
        chk("bw_wdata", sd[0], 32'h000000AB);
        @(negedge clk); chk("bw_rdy", 32'(rdy[0][1]), 32'd1);
        step(); mv[0][1] = 0;
        req(0, 0, 1'b0, 32'h4, SZ_W, 32'h0);
        @(negedge clk); @(negedge clk); @(negedge clk);
        chk("bw_readback", rd[0][0], 32'h11AB3344);
        step(); mv[0][0] = 0;

        // Round robin from reset with both masters requesting continuously.
        rst = 1'b1; step(); rst = 1'b0;
        req(0, 0, 1'b0, 32'h4, SZ_W, 32'h0);
        req(0, 1, 1'b0, 32'h4, SZ_W, 32'h0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rdy[0][0]) begin q_m.push_back(0); q_c.push_back(i); end
            if (rdy[0][1]) begin q_m.push_back(1); q_c.push_back(i); end
        end
        chk("rr_count", 32'(q_m.size()), 32'd4);
        if (q_m.size() == 4) begin
            chk("rr_g0", 32'(q_m[0]), 32'd0);
            chk("rr_g1", 32'(q_m[1]), 32'd1);
            chk("rr_g2", 32'(q_m[2]), 32'd0);
            chk("rr_g3", 32'(q_m[3]), 32'd1);
            chk("rr_first", 32'(q_c[0]), 32'd2);
            chk("rr_gap", 32'(q_c[3] - q_c[0]), 32'd9);
        end
        step(); mv[0][0] = 0; mv[0][1] = 0;

        // Fixed priority: master 1 starves until master 0 drops.
        req(1, 0, 1'b0, 32'h0, SZ_W, 32'h0);
        req(1, 1, 1'b0, 32'h8, SZ_W, 32'h0);
        c0m = 0; c1m = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            c0m += int'(rdy[1][0]);
            c1m += int'(rdy[1][1]);
        end
        chk("fp_m0_count", 32'(c0m), 32'd4);
        chk("fp_m1_count", 32'(c1m), 32'd0);
        step(); mv[1][0] = 0;
        wait_ready(1, 1, 10, n);
        chk("fp_m1_lat", 32'(n), 32'd3);
        step(); mv[1][1] = 0;

        // Master drops valid right after being sampled; transaction still completes.
        req(1, 1, 1'b1, 32'h8, SZ_H, 32'h0000BEEF);
        step(); mv[1][1] = 0;
        wait_ready(1, 1, 10, n);
        step();
        xact(1, 0, 1'b0, 32'h8, SZ_W, 32'h0);

        // Timeout with a silent RAM, then an immediate normal transaction.
        ram_en[0] = 1'b0;
        req(0, 0, 1'b0, 32'h4, SZ_W, 32'h0);
        wait_ready(0, 0, 20, n);
        chk("to_lat", 32'(n), 32'(TO0 + 2));
        chk("to_err", 32'(er[0][0]), 32'd1);
        chk("to_rdata", rd[0][0], 32'h0);
        step(); mv[0][0] = 0; ram_en[0] = 1'b1;
        xact(0, 1, 1'b0, 32'h4, SZ_W, 32'h0);

        // Reset during WAIT abandons the transaction; master 0 wins next.
        ram_en[0] = 1'b0;
        req(0, 1, 1'b0, 32'h4, SZ_W, 32'h0);
        @(negedge clk); @(negedge clk); @(negedge clk);
        step(); rst = 1'b1; mv[0][1] = 0;
        @(negedge clk);
        chk("rstw_rdy0", 32'(rdy[0][0]), 32'd0);
        chk("rstw_rdy1", 32'(rdy[0][1]), 32'd0);
        step(); rst = 1'b0; ram_en[0] = 1'b1;
        req(0, 0, 1'b0, 32'h4, SZ_W, 32'h0);
        req(0, 1, 1'b0, 32'h8, SZ_W, 32'h0);
        @(negedge clk); chk("rstw_sv", 32'(sv[0]), 32'd0);
        @(negedge clk); @(negedge clk);
        chk("rstw_first_m0", 32'(rdy[0][0]), 32'd1);
        chk("rstw_not_m1", 32'(rdy[0][1]), 32'd0);
        step(); mv[0][0] = 0;
        wait_ready(0, 1, 10, n);
        step(); mv[0][1] = 0;

        repeat (4) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
